// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO registers and a start/busy/done handshake.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] srcA,
    input  logic [N-1:0] srcB,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         div0
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0] acc_hi, acc_lo, mag_b;
    logic is_div, neg_q, neg_r, dz;
    logic a_neg, b_neg;
    logic [N-1:0] a_mag, b_mag;
    logic [N:0] add_sum, rem_sh, diff;
    logic [2*N-1:0] mul_nx, div_nx, prod_f;
    logic [N-1:0] q_f, r_f;

    always_comb begin
        a_neg = op[0] & srcA[N-1];
        b_neg = op[0] & srcB[N-1];
        a_mag = a_neg ? -srcA : srcA;
        b_mag = b_neg ? -srcB : srcB;
    end

    // One radix-2 step of each algorithm; the latched op decides which result is kept.
    always_comb begin
        add_sum = acc_lo[0] ? {1'b0, acc_hi} + {1'b0, mag_b} : {1'b0, acc_hi};
        mul_nx  = {add_sum, acc_lo[N-1:1]};
        rem_sh  = {acc_hi, acc_lo[N-1]};
        diff    = rem_sh - {1'b0, mag_b};
        div_nx  = {diff[N] ? rem_sh[N-1:0] : diff[N-1:0], acc_lo[N-2:0], ~diff[N]};
    end

    // A zero divisor leaves |srcA| as remainder, so re-signing it restores srcA.
    always_comb begin
        prod_f = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        q_f    = dz ? '1 : neg_q ? -acc_lo : acc_lo;
        r_f    = neg_r ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (start ? CALC : IDLE)
                 : state == CALC ? (cnt == CW'(1) ? FIX : CALC)
                 : IDLE;

    always_comb busy = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mag_b  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= state == FIX;
            if (state == IDLE && start) begin
                acc_hi <= '0;
                acc_lo <= a_mag;
                mag_b  <= b_mag;
                is_div <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= op[1] && srcB == '0;
                cnt    <= CW'(N);
                div0   <= 1'b0;
            end else if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end else if (state == CALC) begin
                {acc_hi, acc_lo} <= is_div ? div_nx : mul_nx;
                cnt <= cnt - CW'(1);
            end else if (state == FIX) begin
                {hi, lo} <= is_div ? {r_f, q_f} : prod_f;
                div0 <= dz;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit at N=32 and N=8 against a wide-integer model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;
    logic start, hi_we, lo_we, busy, done, div0;
    logic [1:0] op;
    logic [31:0] srcA, srcB, wdata, hi, lo;
    logic st8, hwe8, lwe8, bsy8, dn8, dz8;
    logic [1:0] o8;
    logic [7:0] a8, b8, w8, hi8, lo8;
    int total = 0, bad = 0;

    muldiv_unit #(.N(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div0(div0)
    );
    muldiv_unit #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(st8), .op(o8), .srcA(a8), .srcB(b8),
        .hi_we(hwe8), .lo_we(lwe8), .wdata(w8), .busy(bsy8), .done(dn8),
        .hi(hi8), .lo(lo8), .div0(dz8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values, truncated to n bits.
    function automatic void model(input int n, input logic [1:0] o, input longint ua, input longint ub,
                                  output longint rhi, output longint rlo);
        longint m, sa, sb, p;
        m = (longint'(1) << n) - 1;
        sa = (o[0] && ua[n-1]) ? ua - (longint'(1) << n) : ua;
        sb = (o[0] && ub[n-1]) ? ub - (longint'(1) << n) : ub;
        if (!o[1]) begin
            p = sa * sb;
            rhi = (p >> n) & m;
            rlo = p & m;
        end else if (ub == 0) begin
            rhi = ua;
            rlo = m;
        end else begin
            rhi = (sa % sb) & m;
            rlo = (sa / sb) & m;
        end
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'hFF;
            3: return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
    endtask

    // Runs one N=32 op; poke fires a stray start and an mtlo while busy.
    task automatic op32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke,
                        output int lat, output logic b0, output logic d0);
        logic [31:0] h0, l0;
        bit moved;
        @(negedge clk);
        start = 1'b1; op = o; srcA = x; srcB = y;
        @(negedge clk);
        start = 1'b0; srcA = ~x; srcB = $urandom;
        b0 = busy; d0 = div0; h0 = hi; l0 = lo; moved = 0; lat = 0;
        while (!done && lat < 60) begin
            if (poke && lat == 5) begin
                start = 1'b1; op = ~o; srcA = 32'd9; srcB = 32'd3;
            end else if (poke && lat == 7) begin
                lo_we = 1'b1; wdata = 32'h1234_5678;
            end else begin
                start = 1'b0; lo_we = 1'b0;
            end
            if (hi !== h0 || lo !== l0) moved = 1;
            @(negedge clk);
            lat++;
        end
        start = 1'b0; lo_we = 1'b0;
        chk("hold_during_calc", 64'(moved), 64'd0);
        chk("busy_at_done", 64'(busy), 64'd0);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        st8 = 1'b1; o8 = o; a8 = x; b8 = y;
        @(negedge clk);
        st8 = 1'b0; a8 = ~x; lat = 0;
        while (!dn8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, k, n;
        logic b0, d0;
        longint eh, el;
        logic [1:0] o;
        logic [31:0] x, y;
        logic [7:0] x8, y8;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        st8 = 1'b0; o8 = 2'b00; a8 = '0; b8 = '0; hwe8 = 1'b0; lwe8 = 1'b0; w8 = '0;
        #12;
        chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_div0", div0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        op32(2'b01, 32'hFFFF_FFFD, 32'd5, 0, lat, b0, d0);
        chk("mult_busy0", b0, 1); chk("mult_lat", lat, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF); chk("mult_lo", lo, 32'hFFFF_FFF1);
        op32(2'b00, 32'hFFFF_FFFD, 32'd5, 0, lat, b0, d0);
        chk("multu_hi", hi, 32'h4); chk("multu_lo", lo, 32'hFFFF_FFF1);
        op32(2'b10, 32'd100, 32'd7, 0, lat, b0, d0);
        chk("divu_lo", lo, 14); chk("divu_hi", hi, 2);
        op32(2'b11, 32'hFFFF_FFF9, 32'd2, 0, lat, b0, d0);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD); chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        op32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, b0, d0);
        chk("div_ovf_lo", lo, 32'h8000_0000); chk("div_ovf_hi", hi, 0);
        op32(2'b11, 32'd1234, 32'd0, 0, lat, b0, d0);
        chk("div0_lat", lat, 33); chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 1234); chk("div0_flag", div0, 1);
        op32(2'b00, 32'd2, 32'd3, 0, lat, b0, d0);
        chk("div0_clr_accept", d0, 0); chk("mul23_hi", hi, 0);
        chk("mul23_lo", lo, 6); chk("mul23_div0", div0, 0);

        op32(2'b10, 32'd100, 32'd7, 1, lat, b0, d0);
        chk("poke_lat", lat, 33); chk("poke_lo", lo, 14); chk("poke_hi", hi, 2);

        @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk); hi_we = 1'b0;
        chk("mthi_hi", hi, 32'hA5A5_A5A5); chk("mthi_lo", lo, 14);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h11;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo_hi", hi, 32'h11); chk("mthilo_lo", lo, 32'h11);
        start = 1'b1; op = 2'b00; srcA = 32'd2; srcB = 32'd3; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk); start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("coinc_busy", busy, 1); chk("coinc_hi", hi, 32'h11); chk("coinc_lo", lo, 32'h11);
        wait_done(k);
        chk("coinc_lat", k, 33); chk("coinc_res", lo, 6);

        @(negedge clk); start = 1'b1; op = 2'b00; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk); srcA = 32'd5; srcB = 32'd6;
        wait_done(k);
        chk("held1_lat", k, 33); chk("held1_lo", lo, 12);
        @(negedge clk);
        chk("held2_busy", busy, 1); chk("held2_done", done, 0);
        start = 1'b0;
        wait_done(k);
        chk("held2_lat", k, 33); chk("held2_lo", lo, 30);

        @(negedge clk); start = 1'b1; op = 2'b11; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_hi", hi, 0); chk("arst_lo", lo, 0); chk("arst_busy", busy, 0);
        chk("arst_done", done, 0); chk("arst_div0", div0, 0);
        @(negedge clk); reset_n = 1'b1;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("arst_no_done", n, 0);
        op32(2'b11, 32'hFFFF_FF9C, 32'd7, 0, lat, b0, d0);
        chk("arst_fresh_lo", lo, 32'hFFFF_FFF2); chk("arst_fresh_hi", hi, 32'hFFFF_FFFE);

        for (int i = 0; i < 600; i++) begin
            o = 2'($urandom_range(0, 3)); x = pick32(); y = pick32();
            model(32, o, longint'(x), longint'(y), eh, el);
            op32(o, x, y, 0, lat, b0, d0);
            chk("r32_lat", lat, 33); chk("r32_hi", hi, eh); chk("r32_lo", lo, el);
            chk("r32_div0", div0, 64'(o[1] && y == 0));
        end
        for (int i = 0; i < 600; i++) begin
            o = 2'($urandom_range(0, 3)); x8 = pick8(); y8 = pick8();
            model(8, o, longint'(x8), longint'(y8), eh, el);
            run8(o, x8, y8, lat);
            chk("r8_lat", lat, 9); chk("r8_hi", hi8, eh); chk("r8_lo", lo8, el);
            chk("r8_div0", dz8, 64'(o[1] && y8 == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
